// File: rtl/reg_rename_file_pkg.sv
// Shared widths, reserved constants and packed-bus helpers for the
// architectural register / rename-status table.
package reg_rename_file_pkg;

  localparam int unsigned RRF_XLEN  = 32;
  localparam int unsigned RRF_NREG  = 32;
  localparam int unsigned RRF_ROB_W = 4;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned TAG_NONE = 0;

  // Low bit of element idx inside a packed bus of w-bit elements.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rrf_read_port.sv
// One operand lookup: stored value/status, overridden by this cycle's
// commit data and freed when a commit matches the producer tag.
module rrf_read_port
  import reg_rename_file_pkg::*;
#(
  parameter int unsigned XLEN  = RRF_XLEN,
  parameter int unsigned RW    = 5,
  parameter int unsigned ROB_W = RRF_ROB_W,
  parameter int unsigned NCP   = 1
) (
  input  logic [RW-1:0]       rs_idx,
  input  logic [XLEN-1:0]     reg_val,
  input  logic                reg_busy,
  input  logic [ROB_W-1:0]    reg_tag,
  input  logic [NCP-1:0]      cmt_valid,
  input  logic [NCP*RW-1:0]   cmt_rd,
  input  logic [NCP*ROB_W-1:0] cmt_tag,
  input  logic [NCP*XLEN-1:0] cmt_data,
  output logic [XLEN-1:0]     rd_val,
  output logic                rd_busy,
  output logic [ROB_W-1:0]    rd_tag
);

  logic            byp_hit;
  logic [XLEN-1:0] byp_data;
  logic            freed;

  // Ascending scan so the youngest (highest-index) matching commit wins.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    freed    = 1'b0;
    for (int unsigned k = 0; k < NCP; k++) begin
      if (cmt_valid[k] && cmt_rd[slice_lo(k, RW) +: RW] == rs_idx) begin
        if (rs_idx != RW'(REG_ZERO)) begin
          byp_hit  = 1'b1;
          byp_data = cmt_data[slice_lo(k, XLEN) +: XLEN];
        end
        if (cmt_tag[slice_lo(k, ROB_W) +: ROB_W] == reg_tag) begin
          freed = 1'b1;
        end
      end
    end
  end

  assign rd_val  = byp_hit ? byp_data : reg_val;
  assign rd_busy = reg_busy && !freed;
  assign rd_tag  = rd_busy ? reg_tag : ROB_W'(TAG_NONE);

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register busy bit and ROB tag:
// NRP bypassed operand reads, one rename and NCP commits per cycle.
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter  int unsigned XLEN  = RRF_XLEN,
  parameter  int unsigned NREG  = RRF_NREG,
  parameter  int unsigned ROB_W = RRF_ROB_W,
  parameter  int unsigned NRP   = 2,
  parameter  int unsigned NCP   = 1,
  localparam int unsigned RW    = $clog2(NREG)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  ren_valid,
  input  logic [RW-1:0]         ren_rd,
  input  logic [ROB_W-1:0]      ren_tag,
  input  logic [NRP*RW-1:0]     rs,
  output logic [NRP*XLEN-1:0]   rs_val,
  output logic [NRP-1:0]        rs_busy,
  output logic [NRP*ROB_W-1:0]  rs_tag,
  input  logic [NCP-1:0]        cmt_valid,
  input  logic [NCP*RW-1:0]     cmt_rd,
  input  logic [NCP*ROB_W-1:0]  cmt_tag,
  input  logic [NCP*XLEN-1:0]   cmt_data,
  input  logic                  rollback,
  output logic [XLEN-1:0]       commit_count
);

  logic [XLEN-1:0]  regs [NREG];
  logic [NREG-1:0]  busy;
  logic [ROB_W-1:0] tag  [NREG];
  logic [XLEN-1:0]  cmt_inc;

  always_comb begin
    cmt_inc = '0;
    for (int unsigned k = 0; k < NCP; k++) begin
      cmt_inc = cmt_inc + XLEN'(cmt_valid[k]);
    end
  end

  // Later non-blocking writes override earlier ones: higher commit port beats
  // lower, and the rename beats a same-register commit clear.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        tag[r]  <= '0;
      end
      busy         <= '0;
      commit_count <= '0;
    end else if (rdy_in) begin
      for (int unsigned k = 0; k < NCP; k++) begin
        if (cmt_valid[k] && cmt_rd[slice_lo(k, RW) +: RW] != RW'(REG_ZERO)) begin
          regs[cmt_rd[slice_lo(k, RW) +: RW]] <= cmt_data[slice_lo(k, XLEN) +: XLEN];
        end
      end
      if (rollback) begin
        for (int unsigned r = 0; r < NREG; r++) begin
          tag[r] <= '0;
        end
        busy <= '0;
      end else begin
        for (int unsigned k = 0; k < NCP; k++) begin
          if (cmt_valid[k] && cmt_rd[slice_lo(k, RW) +: RW] != RW'(REG_ZERO) &&
              busy[cmt_rd[slice_lo(k, RW) +: RW]] &&
              tag[cmt_rd[slice_lo(k, RW) +: RW]] == cmt_tag[slice_lo(k, ROB_W) +: ROB_W]) begin
            busy[cmt_rd[slice_lo(k, RW) +: RW]] <= 1'b0;
          end
        end
        if (ren_valid && ren_rd != RW'(REG_ZERO)) begin
          busy[ren_rd] <= 1'b1;
          tag[ren_rd]  <= ren_tag;
        end
      end
      commit_count <= commit_count + cmt_inc;
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [RW-1:0] idx;
    assign idx = rs[p*RW +: RW];

    rrf_read_port #(
      .XLEN  (XLEN),
      .RW    (RW),
      .ROB_W (ROB_W),
      .NCP   (NCP)
    ) u_port (
      .rs_idx    (idx),
      .reg_val   (regs[idx]),
      .reg_busy  (busy[idx]),
      .reg_tag   (tag[idx]),
      .cmt_valid (cmt_valid),
      .cmt_rd    (cmt_rd),
      .cmt_tag   (cmt_tag),
      .cmt_data  (cmt_data),
      .rd_val    (rs_val[p*XLEN +: XLEN]),
      .rd_busy   (rs_busy[p]),
      .rd_tag    (rs_tag[p*ROB_W +: ROB_W])
    );
  end

endmodule

// File: doc/reg_rename_file.md
Name: reg_rename_file

Overview:
- Parametrised architectural register file with a per-register rename status (busy bit + ROB tag), sitting between the dispatcher and the reorder buffer.
- Serves NRP combinational operand lookups per cycle and one rename write per cycle.
- Accepts NCP in-order commit writes per cycle and clears all rename state on rollback.
- Next generation of the single-commit, two-read register/ROB-tag table: explicit busy bit instead of a reserved tag, configurable port counts, defined same-cycle priorities, and a commit counter.

Parameters:
- XLEN, 32, data width.
- NREG, 32, architectural register count (power of 2); RW = log2(NREG).
- ROB_W, 4, ROB tag width.
- NRP, 2, operand read ports.
- NCP, 1, commit ports (1..4); a higher index means a younger instruction.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; when low, all state holds
- ren_valid  in  1  rename request from dispatcher
- ren_rd  in  RW  destination being renamed
- ren_tag  in  ROB_W  ROB tag of new producer
- rs  in  NRP*RW  packed source register indices
- rs_val  out  NRP*XLEN  operand value
- rs_busy  out  NRP  operand still pending
- rs_tag  out  NRP*ROB_W  producer tag; valid only when busy
- cmt_valid  in  NCP  commit strobes from ROB
- cmt_rd  in  NCP*RW  committed destination
- cmt_tag  in  NCP*ROB_W  committed instruction's ROB tag
- cmt_data  in  NCP*XLEN  committed result
- rollback  in  1  flush from CDB
- commit_count  out  XLEN  total committed writes since reset

Behaviour:
- Storage:
  - regs[NREG] holds XLEN-bit data.
  - busy[NREG] holds 1-bit rename status.
  - tag[NREG] holds ROB_W-bit producer tags.
  - Register 0 is hardwired: reads give 0 / busy 0 / tag 0, and writes and renames targeting it are ignored.
- Reset (rst_in high at posedge, regardless of rdy_in):
  - all regs = 0, busy = 0, tag = 0, commit_count = 0.
  - Outputs are combinational from this state, so after reset every rs_val = 0, rs_busy = 0 and rs_tag = 0.
- Read ports (combinational, zero latency), per port p with index s:
  - Value: if any valid commit port k has cmt_rd[k] == s and s != 0, rs_val = cmt_data of the highest such k. Otherwise rs_val = regs[s].
  - Busy: rs_busy = busy[s] && !freed(s), where freed(s) = some valid commit port with cmt_rd == s has cmt_tag == tag[s].
  - Tag: rs_tag = tag[s] when rs_busy = 1, otherwise 0.
  - The same cycle's rename is NOT visible to reads. Sources are looked up before the instruction's own destination is renamed.
- Sequential update at posedge, when rdy_in = 1 and rst_in = 0:
  1. Commit: each valid port with a nonzero destination writes regs[cmt_rd] = cmt_data. On a same-destination conflict the highest port index wins.
  2. Commit clear: busy[cmt_rd] is cleared only if busy is set and tag[cmt_rd] == cmt_tag. A commit whose tag does not match (a newer producer exists) leaves busy/tag untouched.
  3. Rollback: clears every busy bit and tag. Commit writes in the same cycle still update regs. A rename in the same cycle is discarded.
  4. Rename (no rollback): sets busy[ren_rd] = 1 and tag[ren_rd] = ren_tag. Rename beats a commit-clear to the same register in the same cycle.
  5. Counter: commit_count += popcount(valid commit ports with any rd, including x0). The count wraps modulo 2^XLEN and is not affected by rollback.
- rdy_in = 0: no state change. Inputs presented that cycle are dropped, and the upstream blocks are responsible for holding them. Reads continue to reflect current state plus the commit bypass.
- No internal FSM beyond the register state. All ports are single-cycle, with no handshake back-pressure.

Decomposition:
- Shared package/include holds:
  - the XLEN, NREG, ROB_W widths
  - the REG_ZERO constant
  - the TAG_NONE = 0 constant
  - helper functions for packed-slice indexing
- Sub-module rrf_read_port, instantiated NRP times: combinational lookup with commit bypass and tag-match free logic.
- Top level holds the storage arrays, update priority logic and counter.

Test Plan:
- Reset, then read x5 and x0 on both ports → val 0, busy 0, tag 0; commit_count = 0.
- Rename x3 with tag 7; next cycle read x3 → busy 1, tag 7. Then commit x3, tag 7, data 0xDEADBEEF → the same-cycle read shows val 0xDEADBEEF, busy 0; next cycle regs[3] = 0xDEADBEEF, busy 0.
- Rename x4 tag 2, then rename x4 tag 5, then commit x4 tag 2, data 0x11 → regs[4] = 0x11 but busy stays 1 with tag 5.
- Same cycle: commit x6 tag 1 (matches) and rename x6 tag 9 → busy 1, tag 9, regs[6] updated.
- With x1..x3 busy, rollback plus commit x2 data 0x55 plus rename x7 → all busy 0, regs[2] = 0x55, x7 not busy.
- NCP = 2, both ports commit x8 with data 0xA and 0xB → regs[8] = 0xB and commit_count += 2. Repeat with rdy_in = 0 → nothing changes.
